// File: rtl/pe_pkg.sv
// Shared types and default widths for the PE input scheduler.
// Holds the FSM state encoding and the skid-buffer entry layout.
package pe_pkg;

    localparam int PE_DATA_W = 8;
    localparam int PE_ADDR_W = 10;
    localparam int PE_LEN_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } pe_state_t;

    typedef struct packed {
        logic [PE_DATA_W-1:0] data;
        logic                 row_last;
        logic                 tile_last;
    } pe_skid_t;

endpackage

// File: rtl/pe_skid_fifo2.sv
// Two-entry skid FIFO holding returned buffer words ahead of the PE.
// Ports: i_clk/i_rst_n, i_push/i_wdata, i_pop, o_rdata (head), o_count.
module pe_skid_fifo2
    import pe_pkg::*;
#(
    parameter type entry_t = pe_skid_t
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  entry_t     i_wdata,
    input  logic       i_pop,
    output entry_t     o_rdata,
    output logic [1:0] o_count
);

    entry_t     r_mem [2];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_count;

    logic w_wr;
    logic w_rd;

    assign w_rd = i_pop && (r_count != 2'd0);
    // A push into a full FIFO is only legal alongside a pop.
    assign w_wr = i_push && ((r_count != 2'd2) || w_rd);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_wr) r_wptr <= ~r_wptr;
            if (w_rd) r_rptr <= ~r_rptr;
            r_count <= r_count + {1'b0, w_wr} - {1'b0, w_rd};
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

    a_no_overflow: assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        !(i_push && !i_pop && (r_count == 2'd2))
    );

endmodule

// File: rtl/pe_input_scheduler.sv
// Walks a 2-D tile in the input buffer and streams it to the PE.
// Ports: PE_clk/rst_n; start + base_addr/row_len/row_cnt/stride;
//   buf_rd_en/buf_rd_addr/buf_rd_data (1-cycle latency read port);
//   pe_valid/pe_ready/pe_data/pe_row_last/pe_tile_last; busy, done.
module pe_input_scheduler
    import pe_pkg::*;
#(
    parameter int DATA_W = PE_DATA_W,
    parameter int ADDR_W = PE_ADDR_W,
    parameter int LEN_W  = PE_LEN_W
) (
    input  logic              PE_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  row_len,
    input  logic [LEN_W-1:0]  row_cnt,
    input  logic [ADDR_W-1:0] stride,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    input  logic [DATA_W-1:0] buf_rd_data,
    output logic              pe_valid,
    input  logic              pe_ready,
    output logic [DATA_W-1:0] pe_data,
    output logic              pe_row_last,
    output logic              pe_tile_last,
    output logic              busy,
    output logic              done
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              row_last;
        logic              tile_last;
    } entry_t;

    pe_state_t         r_state;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_stride;
    logic [ADDR_W-1:0] r_row_base;
    logic [LEN_W-1:0]  r_col;
    logic [LEN_W-1:0]  r_row;
    logic              r_pend;
    logic              r_pend_row_last;
    logic              r_pend_tile_last;
    logic              r_done;

    logic       w_col_last;
    logic       w_row_last;
    logic       w_credit;
    logic       w_issue;
    logic [1:0] w_count;
    entry_t     w_fifo_head;
    entry_t     w_in;
    entry_t     w_head;
    logic       w_push;
    logic       w_pop;
    logic       w_accept;

    assign w_col_last = (r_col == r_len - LEN_W'(1));
    assign w_row_last = (r_row == r_cnt - LEN_W'(1));

    // Words in the FIFO plus the read landing this cycle must leave room.
    assign w_credit = ({1'b0, w_count} + {2'b00, r_pend}) < 3'd2;
    assign w_issue  = (r_state == ST_RUN) && w_credit;

    assign buf_rd_en   = w_issue;
    assign buf_rd_addr = r_row_base + ADDR_W'(r_col);

    // Returning data bypasses the FIFO when it is empty.
    always_comb begin
        w_in.data      = buf_rd_data;
        w_in.row_last  = r_pend_row_last;
        w_in.tile_last = r_pend_tile_last;
        if (w_count != 2'd0) begin
            w_head = w_fifo_head;
        end else if (r_pend) begin
            w_head = w_in;
        end else begin
            w_head = '0;
        end
    end

    assign pe_valid = (w_count != 2'd0) || r_pend;
    assign w_accept = pe_valid && pe_ready;
    assign w_pop    = (w_count != 2'd0) && pe_ready;
    assign w_push   = r_pend && !((w_count == 2'd0) && pe_ready);

    assign pe_data      = w_head.data;
    assign pe_row_last  = w_head.row_last;
    assign pe_tile_last = w_head.tile_last;

    pe_skid_fifo2 #(
        .entry_t (entry_t)
    ) u_skid (
        .i_clk   (PE_clk),
        .i_rst_n (rst_n),
        .i_push  (w_push),
        .i_wdata (w_in),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_head),
        .o_count (w_count)
    );

    always_ff @(posedge PE_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_len            <= '0;
            r_cnt            <= '0;
            r_stride         <= '0;
            r_row_base       <= '0;
            r_col            <= '0;
            r_row            <= '0;
            r_pend           <= 1'b0;
            r_pend_row_last  <= 1'b0;
            r_pend_tile_last <= 1'b0;
            r_done           <= 1'b0;
        end else begin
            r_pend           <= w_issue;
            r_pend_row_last  <= w_issue && w_col_last;
            r_pend_tile_last <= w_issue && w_col_last && w_row_last;
            r_done           <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_len      <= row_len;
                        r_cnt      <= row_cnt;
                        r_stride   <= stride;
                        r_row_base <= base_addr;
                        r_col      <= '0;
                        r_row      <= '0;
                        if ((row_len == '0) || (row_cnt == '0)) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_issue) begin
                        if (w_col_last) begin
                            r_col      <= '0;
                            r_row      <= r_row + LEN_W'(1);
                            r_row_base <= r_row_base + r_stride;
                            if (w_row_last) r_state <= ST_DRAIN;
                        end else begin
                            r_col <= r_col + LEN_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_accept && w_head.tile_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // busy covers the accepting start cycle through the done cycle.
    assign busy = (r_state != ST_IDLE) || (start && rst_n);
    assign done = r_done;

endmodule

// File: tb/tb_pe_input_scheduler.sv
// Directed bench for pe_input_scheduler with a 1-cycle buffer model.
// Ports: none; drives the DUT and prints one summary line.
module tb_pe_input_scheduler;

    logic       PE_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] base_addr = '0;
    logic [7:0] row_len = '0;
    logic [7:0] row_cnt = '0;
    logic [9:0] stride = '0;
    logic       buf_rd_en;
    logic [9:0] buf_rd_addr;
    logic [7:0] buf_rd_data;
    logic       pe_valid;
    logic       pe_ready = 1'b1;
    logic [7:0] pe_data;
    logic       pe_row_last;
    logic       pe_tile_last;
    logic       busy;
    logic       done;

    pe_input_scheduler dut (
        .PE_clk       (PE_clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .row_len      (row_len),
        .row_cnt      (row_cnt),
        .stride       (stride),
        .buf_rd_en    (buf_rd_en),
        .buf_rd_addr  (buf_rd_addr),
        .buf_rd_data  (buf_rd_data),
        .pe_valid     (pe_valid),
        .pe_ready     (pe_ready),
        .pe_data      (pe_data),
        .pe_row_last  (pe_row_last),
        .pe_tile_last (pe_tile_last),
        .busy         (busy),
        .done         (done)
    );

    always #5 PE_clk = ~PE_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;

    always @(posedge PE_clk) cyc <= cyc + 1;

    function automatic logic [7:0] mem_f(input logic [9:0] a);
        return a[7:0] ^ {6'b0, a[9:8]} ^ 8'hC3;
    endfunction

    // Buffer: data one cycle after the strobe, garbage otherwise.
    always @(posedge PE_clk)
        buf_rd_data <= buf_rd_en ? mem_f(buf_rd_addr) : 8'hEE;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [9:0] rd_q [$];
    logic [9:0] acc_q [$];
    int  done_cnt, done_cyc, first_rd_cyc, first_val_cyc, busy_cnt;
    bit  done_seen = 1'b0;
    bit  chk_rd_exact = 1'b0;
    bit  rdy_mode = 1'b0;
    int  n_exp = 0;
    logic       prev_stall = 1'b0;
    logic [9:0] prev_word = '0;

    initial forever begin
        @(negedge PE_clk);
        if (rst_n) begin
            if (prev_stall) begin
                check("stall_valid", 32'(pe_valid), 32'd1);
                check("stall_word",
                      32'({pe_tile_last, pe_row_last, pe_data}),
                      32'(prev_word));
            end
            if (chk_rd_exact)
                check("rd_en_credit", 32'(buf_rd_en),
                      32'((rd_q.size() - acc_q.size() < 2)
                          && (rd_q.size() < n_exp)));
            if (buf_rd_en) begin
                check("credit_bound",
                      32'(rd_q.size() - acc_q.size() < 2), 32'd1);
                rd_q.push_back(buf_rd_addr);
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
            if (pe_valid && first_val_cyc < 0) first_val_cyc = cyc;
            if (pe_valid && pe_ready)
                acc_q.push_back({pe_tile_last, pe_row_last, pe_data});
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                done_seen = 1'b1;
            end
            if (busy) busy_cnt++;
            prev_stall = pe_valid && !pe_ready;
            prev_word  = {pe_tile_last, pe_row_last, pe_data};
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial forever begin
        @(posedge PE_clk);
        #1;
        pe_ready = rdy_mode ? (cyc % 3 == 0) : 1'b1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge PE_clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        rd_q.delete();
        acc_q.delete();
        done_cnt = 0;
        done_cyc = -1;
        done_seen = 1'b0;
        first_rd_cyc = -1;
        first_val_cyc = -1;
        busy_cnt = 0;
    endtask

    task automatic start_tile(input logic [9:0] b, input logic [7:0] l,
                              input logic [7:0] c, input logic [9:0] s);
        base_addr = b;
        row_len = l;
        row_cnt = c;
        stride = s;
        start = 1'b1;
        t0 = cyc;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max);
        for (int k = 0; k < max && !done_seen; k++) step(1);
        check("done_timeout", 32'(done_seen), 32'd1);
    endtask

    task automatic check_tile(input string tag, input logic [9:0] ea [8],
                              input int n, input int len);
        check({tag, "_nrd"}, rd_q.size(), n);
        check({tag, "_nacc"}, acc_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < rd_q.size())
                check({tag, "_addr"}, 32'(rd_q[i]), 32'(ea[i]));
            if (i < acc_q.size())
                check({tag, "_word"}, 32'(acc_q[i]),
                      32'({i == n - 1, (i % len) == len - 1,
                           mem_f(ea[i])}));
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_rd_en"}, 32'(buf_rd_en), 32'd0);
        check({tag, "_rd_addr"}, 32'(buf_rd_addr), 32'd0);
        check({tag, "_valid"}, 32'(pe_valid), 32'd0);
        check({tag, "_data"}, 32'(pe_data), 32'd0);
        check({tag, "_row_last"}, 32'(pe_row_last), 32'd0);
        check({tag, "_tile_last"}, 32'(pe_tile_last), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    logic [9:0] ea_basic [8];
    logic [9:0] ea_wrap [8];

    initial begin
        ea_basic = '{10'h010, 10'h011, 10'h012, 10'h013,
                     10'h030, 10'h031, 10'h032, 10'h033};
        ea_wrap  = '{10'h3FE, 10'h3FF, 10'h000, 10'h001,
                     10'h000, 10'h000, 10'h000, 10'h000};
        clear_mon();

        step(2);
        check_reset_outs("reset");
        rst_n = 1'b1;
        step(2);

        // Basic tile, PE always ready.
        clear_mon();
        start_tile(10'h010, 8'd4, 8'd2, 10'h020);
        wait_done(40);
        step(3);
        check_tile("basic", ea_basic, 8, 4);
        check("basic_first_rd", first_rd_cyc, t0 + 1);
        check("basic_first_valid", first_val_cyc, t0 + 2);
        check("basic_done_cyc", done_cyc, t0 + 10);
        check("basic_done_cnt", done_cnt, 1);
        check("basic_busy_cnt", busy_cnt, 11);

        // Backpressure with ready pattern 1,0,0.
        clear_mon();
        rdy_mode = 1'b1;
        start_tile(10'h010, 8'd4, 8'd2, 10'h020);
        n_exp = 8;
        chk_rd_exact = 1'b1;
        wait_done(100);
        chk_rd_exact = 1'b0;
        rdy_mode = 1'b0;
        step(3);
        check_tile("bp", ea_basic, 8, 4);
        check("bp_done_cnt", done_cnt, 1);

        // Address wrap.
        clear_mon();
        start_tile(10'h3FE, 8'd4, 8'd1, 10'h000);
        wait_done(40);
        step(3);
        check_tile("wrap", ea_wrap, 4, 4);
        check("wrap_done_cyc", done_cyc, t0 + 6);
        check("wrap_busy_cnt", busy_cnt, 7);

        // Zero row length.
        clear_mon();
        start_tile(10'h100, 8'd0, 8'd3, 10'h010);
        wait_done(10);
        step(3);
        check("zl_nrd", rd_q.size(), 0);
        check("zl_nacc", acc_q.size(), 0);
        check("zl_done_cyc", done_cyc, t0 + 1);
        check("zl_done_cnt", done_cnt, 1);
        check("zl_busy_cnt", busy_cnt, 2);

        // Zero row count.
        clear_mon();
        start_tile(10'h100, 8'd5, 8'd0, 10'h010);
        wait_done(10);
        step(3);
        check("zc_nrd", rd_q.size(), 0);
        check("zc_done_cyc", done_cyc, t0 + 1);
        check("zc_busy_cnt", busy_cnt, 2);

        // Start pulses during RUN and during DONE are ignored.
        clear_mon();
        start_tile(10'h010, 8'd4, 8'd2, 10'h020);
        step(3);
        base_addr = 10'h200;
        row_len = 8'd2;
        row_cnt = 8'd1;
        stride = 10'h005;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(5);
        check("sb_done_now", 32'(done), 32'd1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        check_tile("sb", ea_basic, 8, 4);
        check("sb_done_cnt", done_cnt, 1);
        check("sb_done_cyc", done_cyc, t0 + 10);
        check("sb_busy_cnt", busy_cnt, 11);

        // Reset after three accepted words.
        clear_mon();
        start_tile(10'h010, 8'd4, 8'd2, 10'h020);
        for (int k = 0; k < 20 && acc_q.size() < 3; k++) step(1);
        check("mr_acc3", acc_q.size(), 3);
        rst_n = 1'b0;
        #2;
        check_reset_outs("mr");
        step(1);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge PE_clk);
            check("mr_idle_valid", 32'(pe_valid), 32'd0);
            check("mr_idle_rd_en", 32'(buf_rd_en), 32'd0);
            check("mr_idle_busy", 32'(busy), 32'd0);
            @(posedge PE_clk);
            #1;
        end
        clear_mon();
        start_tile(10'h010, 8'd4, 8'd2, 10'h020);
        wait_done(40);
        step(3);
        check_tile("mr_fresh", ea_basic, 8, 4);
        check("mr_fresh_done_cyc", done_cyc, t0 + 10);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_input_scheduler.md
Name: pe_input_scheduler

Overview:
- Sequences the PE input-preparation path: on `start`, walks a 2-D tile in the input buffer and streams the words to the PE with a valid/ready handshake.
- Generates buffer read addresses as row × stride + column and absorbs the buffer's 1-cycle read latency.
- Holds up to 2 words internally, so PE backpressure never drops data.
- Sits between the input SRAM read port and the PE operand input, in the `PE_clk` domain.

Parameters:
- DATA_W, 8, width of one buffer/PE word
- ADDR_W, 10, buffer address width
- LEN_W, 8, width of the row-length and row-count fields

Ports:
- PE_clk  in  1  single block clock; all logic on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  tile start address; latched at accepted start
- row_len  in  LEN_W  words per row; latched at accepted start
- row_cnt  in  LEN_W  number of rows; latched at accepted start
- stride  in  ADDR_W  address step between row starts; latched at accepted start
- buf_rd_en  out  1  buffer read strobe
- buf_rd_addr  out  ADDR_W  buffer read address
- buf_rd_data  in  DATA_W  read data, valid exactly 1 cycle after buf_rd_en
- pe_valid  out  1  pe_data is valid
- pe_ready  in  1  PE accepts the word when pe_valid && pe_ready
- pe_data  out  DATA_W  operand word
- pe_row_last  out  1  qualifies pe_data as the last word of a row
- pe_tile_last  out  1  qualifies pe_data as the last word of the tile
- busy  out  1  high from accepted start until the done cycle inclusive
- done  out  1  one-cycle pulse when the tile completes

Behaviour:
- Reset (async assert, sync release): state IDLE; all counters cleared; skid buffer emptied; any in-flight read discarded.
  - Reset values: buf_rd_en=0, buf_rd_addr=0, pe_valid=0, pe_data=0, pe_row_last=0, pe_tile_last=0, busy=0, done=0.
- State IDLE:
  - start=1 latches base_addr/row_len/row_cnt/stride and sets busy=1.
  - If row_len=0 or row_cnt=0: go to DONE, with no reads issued.
  - Otherwise go to RUN.
- State RUN, read issue:
  - buf_rd_en=1 when (skid occupancy + outstanding reads) < 2 and words remain to issue.
  - Address = row_base + col. Column counter wraps at row_len; row_base += stride at each wrap.
  - All address arithmetic is modulo 2^ADDR_W (wraps silently).
  - Each read tags its data with row_last (col = row_len−1) and tile_last (additionally row = row_cnt−1).
- Skid buffer:
  - 2-entry FIFO. Returned data is written 1 cycle after buf_rd_en.
  - The head drives pe_data/pe_valid/pe_*_last.
  - A simultaneous write and pop keeps occupancy constant.
  - The credit check guarantees the FIFO never overflows; an overflow is an assertion failure.
- Handshake:
  - pe_data and the last flags are stable while pe_valid && !pe_ready.
  - pe_valid never drops without acceptance.
- State RUN → DRAIN when the last read has been issued.
- State DRAIN → DONE on the cycle the tile_last word is accepted.
- State DONE:
  - done=1 for exactly one cycle, busy still 1.
  - Next cycle: IDLE with busy=0.
  - start during DONE is ignored; start while busy is ignored.
- Latency:
  - start accepted at cycle T (registered): buf_rd_en at T+1, pe_valid at T+2.
  - With pe_ready held high, one word is delivered per cycle: N words take cycles T+2 .. T+N+1, and done=1 at T+N+2.
- Reset mid-operation: immediate return to IDLE. Stale buf_rd_data returning after reset release is ignored.

Decomposition:
- Shared package pe_pkg:
  - DATA_W/ADDR_W/LEN_W defaults.
  - State enum (IDLE, RUN, DRAIN, DONE).
  - Skid-entry struct {data, row_last, tile_last}.
- One sub-module: pe_skid_fifo2.
  - 2-entry FIFO with count output, push/pop, reset to empty.
- Address generation and the FSM stay in pe_input_scheduler.

Test Plan:
- Basic tile:
  - Stimulus: base=0x010, row_len=4, row_cnt=2, stride=0x020, pe_ready=1.
  - Required: reads 0x010–0x013 then 0x030–0x033; pe_row_last on words 4 and 8; pe_tile_last on word 8; done at T+10.
- Backpressure:
  - Stimulus: same tile with pe_ready toggling 1,0,0,1,…
  - Required: word order preserved; pe_data stable while stalled; buf_rd_en stops when occupancy + outstanding = 2.
- Address wrap:
  - Stimulus: base=0x3FE, row_len=4, row_cnt=1.
  - Required: addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Zero-length tile:
  - Stimulus: row_len=0 (and separately row_cnt=0).
  - Required: no buf_rd_en; done pulse at T+1; busy high for exactly 2 cycles.
- Start while busy:
  - Stimulus: second start pulse during RUN and during DONE.
  - Required: ignored; only one done pulse; latched parameters unchanged.
- Reset mid-tile:
  - Stimulus: rst_n low for 1 cycle after 3 words are accepted.
  - Required: all outputs at reset values immediately; no pe_valid until a new start; a fresh tile then runs correctly.
